renaming_table_mp: RTL and testbench
====================================

# renaming_table_mp

Parametrised multi-port register renaming table for the out-of-order core. It sits between decode/dispatch and the RRF/ROB. It tracks, per architectural register, whether a rename is in flight (busy) and which RRF entry holds the newest value (rrftag). Over the fixed 4-read/2-dispatch/2-commit table, it adds parametrised port counts, tag-qualified commit clear, x0 hard-wiring, global flush, and optional branch checkpoints.

## Interface
Parameters:
- ARF_N, 32: number of architectural registers; ARF_W = $clog2(ARF_N).
- RRF_N, 64: number of RRF entries; TAG_W = $clog2(RRF_N).
- RD_PORTS, 4: lookup ports.
- DP_PORTS, 2: dispatch ports; higher index = younger instruction.
- COM_PORTS, 2: commit ports.
- CKPT_N, 4: checkpoint slots; used only with RT_CKPT_EN; power of 2; CKPT_W = $clog2(CKPT_N).

Ports (port-k fields packed LSB-first):
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_rd_addr  in  RD_PORTS*ARF_W  lookup addresses.
- o_rd_busy  out  RD_PORTS  busy bit of each looked-up register.
- o_rd_rrftag  out  RD_PORTS*TAG_W  rrftag of each looked-up register.
- i_dp_vld / i_dp_rd_wr_en  in  DP_PORTS each  dispatch valid / writes rd.
- i_dp_ptr  in  DP_PORTS*TAG_W  allocated RRF entry.
- i_dp_rd_wr_addr  in  DP_PORTS*ARF_W  destination register.
- i_com_vld  in  COM_PORTS  commit valid; asserted only for rd-writing instructions.
- i_com_rd_wr_addr  in  COM_PORTS*ARF_W  committed rd.
- i_com_ptr  in  COM_PORTS*TAG_W  RRF entry being retired.
- i_flush  in  1  discard all in-flight renames.
- i_ckpt_save  in  1  take a checkpoint this cycle.
- o_ckpt_id  out  CKPT_W  slot that a save this cycle will occupy (tail).
- o_ckpt_full  out  1  no free checkpoint slot.
- i_ckpt_restore  in  1  mispredict recovery.
- i_ckpt_restore_id  in  CKPT_W  slot to restore.
- i_ckpt_release  in  1  oldest checkpoint (head) resolved correctly; free it.

## Operation
- State:
  - busy[ARF_N]
  - rrftag[ARF_N][TAG_W]
  - with RT_CKPT_EN: snapshots, head/tail pointers, and count[CKPT_W:0].
- Register 0: always reads busy=0, rrftag=0. Dispatches and commits to register 0 are ignored.
- Dispatch port k (i_dp_vld[k] && i_dp_rd_wr_en[k]): sets busy and writes rrftag = i_dp_ptr[k]. Without rd_wr_en, rrftag is untouched.
- Same-address dispatch on several ports: the highest port index wins the rrftag.
- Commit port k: clears busy only when busy=1 and rrftag == i_com_ptr[k]. A mismatching tag means a younger rename exists, so busy stays 1.
- Commit and dispatch to the same register in the same cycle: the dispatch wins (busy=1, new tag).
- Lookups are combinational from registered state. There is no same-cycle dispatch bypass; intra-group dependencies are resolved in decode.
- i_flush: next state has all busy=0; rrftag is unchanged. Same-cycle dispatches and commits are ignored.
- Priority: flush > restore > dispatch/commit.

## Timing
- Reset (asynchronous, immediate):
  - busy=0, rrftag=0, head=tail=count=0.
  - Hence o_rd_busy=0, o_rd_rrftag=0, o_ckpt_id=0, o_ckpt_full=0 (1 when RT_CKPT_EN is undefined).
- Reset asserted mid-operation discards all renames and checkpoints. The first update after release is at the first posedge with rst_n=1.
- Updates land at the posedge. Lookups see them in the following cycle.
- o_ckpt_id and o_ckpt_full are combinational from registered pointers.

## Configuration
- RT_CKPT_EN defined:
  - i_ckpt_save with !o_ckpt_full stores the next-state busy/rrftag (including this cycle's dispatches and commits) into slot tail; then tail++ and count++. A save while full is dropped.
  - Commits also apply the tag-qualified busy clear to every live snapshot.
  - i_ckpt_restore:
    - Live state <= snapshot[id], with same-cycle commits applied to it.
    - Same-cycle dispatches and saves are dropped.
    - tail <= id, freeing slot id and all younger slots.
  - i_ckpt_release: head++ and count--, wrapping modulo CKPT_N.
    - With restore to id != head: both apply.
    - With restore to id == head: release is ignored.
    - Release while count=0 is ignored.
  - i_flush also sets head=tail=count=0.
- RT_CKPT_EN undefined: checkpoint inputs are ignored, o_ckpt_id=0, o_ckpt_full=1. Only flush recovery exists.

## Test plan
- Reset, then dispatch p0 rd=5 ptr=12 -> next cycle lookup 5 gives busy=1, tag=12. Commit rd=5 ptr=12 -> busy=0.
- Dispatch p0 rd=7 ptr=3 and p1 rd=7 ptr=4 in the same cycle -> tag=4. Later commit rd=7 ptr=3 -> busy stays 1; commit ptr=4 -> busy=0.
- Dispatch rd=0 ptr=9 -> lookup 0 gives busy=0, tag=0. Commit rd=9 ptr=2 alongside dispatch rd=9 ptr=20 in the same cycle -> busy=1, tag=20.
- RT_CKPT_EN, CKPT_N=4:
  - Dispatch rd=3 ptr=1 with save (id 0), then dispatch rd=3 ptr=2.
  - Restore id 0 -> tag=1, busy=1, o_ckpt_id=0.
  - 4 saves -> o_ckpt_full=1, and a 5th save is dropped.
- RT_CKPT_EN: save (id 0), save (id 1), then release + restore id 1 in the same cycle -> count=0, head=tail=1.
- Assert rst_n=0 mid-burst between clock edges -> all outputs are 0 immediately, before the next posedge. i_flush -> every busy=0 and tags are retained.

Source files
------------

// File: rtl/renaming_table_mp.sv
// renaming_table_mp: multi-port rename table holding busy + newest RRF tag per architectural register.
// Define RT_CKPT_EN to add branch checkpoint snapshots; otherwise only flush recovery exists.
module renaming_table_mp #(
  parameter int unsigned ARF_N     = 32,
  parameter int unsigned RRF_N     = 64,
  parameter int unsigned RD_PORTS  = 4,
  parameter int unsigned DP_PORTS  = 2,
  parameter int unsigned COM_PORTS = 2,
  parameter int unsigned CKPT_N    = 4,
  localparam int unsigned ARF_W    = $clog2(ARF_N),
  localparam int unsigned TAG_W    = $clog2(RRF_N),
  localparam int unsigned CKPT_W   = $clog2(CKPT_N)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [RD_PORTS*ARF_W-1:0]     i_rd_addr,
  output logic [RD_PORTS-1:0]           o_rd_busy,
  output logic [RD_PORTS*TAG_W-1:0]     o_rd_rrftag,
  input  logic [DP_PORTS-1:0]           i_dp_vld,
  input  logic [DP_PORTS-1:0]           i_dp_rd_wr_en,
  input  logic [DP_PORTS*TAG_W-1:0]     i_dp_ptr,
  input  logic [DP_PORTS*ARF_W-1:0]     i_dp_rd_wr_addr,
  input  logic [COM_PORTS-1:0]          i_com_vld,
  input  logic [COM_PORTS*ARF_W-1:0]    i_com_rd_wr_addr,
  input  logic [COM_PORTS*TAG_W-1:0]    i_com_ptr,
  input  logic                          i_flush,
  input  logic                          i_ckpt_save,
  output logic [CKPT_W-1:0]             o_ckpt_id,
  output logic                          o_ckpt_full,
  input  logic                          i_ckpt_restore,
  input  logic [CKPT_W-1:0]             i_ckpt_restore_id,
  input  logic                          i_ckpt_release
);

  typedef logic [TAG_W-1:0] tag_t;

  logic [ARF_N-1:0] busy_q;
  logic [ARF_N-1:0] busy_d;
  logic [ARF_N-1:0] busy_n;
  tag_t             tag_q [ARF_N];
  tag_t             tag_d [ARF_N];
  tag_t             tag_n [ARF_N];

  // Lookups straight from registered state; register 0 is hard-wired to zero
  always_comb begin
    o_rd_busy   = '0;
    o_rd_rrftag = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      if (i_rd_addr[k*ARF_W +: ARF_W] != '0) begin
        o_rd_busy[k]                  = busy_q[i_rd_addr[k*ARF_W +: ARF_W]];
        o_rd_rrftag[k*TAG_W +: TAG_W] = tag_q[i_rd_addr[k*ARF_W +: ARF_W]];
      end
    end
  end

  // Normal update: tag-qualified commit clears first, then dispatches in age order so they win
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    for (int k = 0; k < COM_PORTS; k++) begin
      if (i_com_vld[k] && (i_com_rd_wr_addr[k*ARF_W +: ARF_W] != '0)
          && busy_q[i_com_rd_wr_addr[k*ARF_W +: ARF_W]]
          && (tag_q[i_com_rd_wr_addr[k*ARF_W +: ARF_W]] == i_com_ptr[k*TAG_W +: TAG_W])) begin
        busy_d[i_com_rd_wr_addr[k*ARF_W +: ARF_W]] = 1'b0;
      end
    end
    for (int k = 0; k < DP_PORTS; k++) begin
      if (i_dp_vld[k] && i_dp_rd_wr_en[k] && (i_dp_rd_wr_addr[k*ARF_W +: ARF_W] != '0)) begin
        busy_d[i_dp_rd_wr_addr[k*ARF_W +: ARF_W]] = 1'b1;
        tag_d[i_dp_rd_wr_addr[k*ARF_W +: ARF_W]]  = i_dp_ptr[k*TAG_W +: TAG_W];
      end
    end
  end

`ifdef RT_CKPT_EN
  logic [ARF_N-1:0]  snap_busy_q [CKPT_N];
  logic [ARF_N-1:0]  snap_busy_d [CKPT_N];
  tag_t              snap_tag_q  [CKPT_N][ARF_N];
  logic [CKPT_W-1:0] head_q;
  logic [CKPT_W-1:0] head_d;
  logic [CKPT_W-1:0] tail_q;
  logic [CKPT_W-1:0] tail_d;
  logic [CKPT_W:0]   count_q;
  logic [CKPT_W:0]   count_d;
  logic              full;
  logic              save_ok;
  logic              rel_ok;

  assign full        = (count_q == (CKPT_W+1)'(CKPT_N));
  assign o_ckpt_id   = tail_q;
  assign o_ckpt_full = full;
  assign save_ok     = i_ckpt_save && !full && !i_ckpt_restore && !i_flush;
  assign rel_ok      = i_ckpt_release && (count_q != '0)
                       && !(i_ckpt_restore && (i_ckpt_restore_id == head_q));

  // Commits retire against each snapshot's own tags, so a restored state sees them too
  always_comb begin
    snap_busy_d = snap_busy_q;
    for (int s = 0; s < CKPT_N; s++) begin
      for (int k = 0; k < COM_PORTS; k++) begin
        if (i_com_vld[k] && (i_com_rd_wr_addr[k*ARF_W +: ARF_W] != '0)
            && snap_busy_q[s][i_com_rd_wr_addr[k*ARF_W +: ARF_W]]
            && (snap_tag_q[s][i_com_rd_wr_addr[k*ARF_W +: ARF_W]] == i_com_ptr[k*TAG_W +: TAG_W])) begin
          snap_busy_d[s][i_com_rd_wr_addr[k*ARF_W +: ARF_W]] = 1'b0;
        end
      end
    end
  end

  // Checkpoint ring pointers; a restore truncates the ring at the restored slot
  always_comb begin
    head_d  = head_q + CKPT_W'(rel_ok);
    tail_d  = tail_q + CKPT_W'(save_ok);
    count_d = count_q + (CKPT_W+1)'(save_ok) - (CKPT_W+1)'(rel_ok);
    if (i_ckpt_restore) begin
      tail_d  = i_ckpt_restore_id;
      count_d = {1'b0, CKPT_W'(i_ckpt_restore_id - head_d)};
    end
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int s = 0; s < CKPT_N; s++) begin
        snap_busy_q[s] <= '0;
        for (int i = 0; i < ARF_N; i++) snap_tag_q[s][i] <= '0;
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      snap_busy_q <= snap_busy_d;
      if (save_ok) begin
        snap_busy_q[tail_q] <= busy_d;
        snap_tag_q[tail_q]  <= tag_d;
      end
    end
  end
`else
  logic unused_ckpt;
  assign unused_ckpt = ^{i_ckpt_save, i_ckpt_restore, i_ckpt_restore_id, i_ckpt_release};
  assign o_ckpt_id   = '0;
  assign o_ckpt_full = 1'b1;
`endif

  // Next-state select: flush > restore > dispatch/commit
  always_comb begin
    busy_n = busy_d;
    tag_n  = tag_d;
`ifdef RT_CKPT_EN
    if (i_ckpt_restore) begin
      busy_n = snap_busy_d[i_ckpt_restore_id];
      tag_n  = snap_tag_q[i_ckpt_restore_id];
    end
`endif
    if (i_flush) begin
      busy_n = '0;
      tag_n  = tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int i = 0; i < ARF_N; i++) tag_q[i] <= '0;
    end else begin
      busy_q <= busy_n;
      tag_q  <= tag_n;
    end
  end

endmodule

// File: tb/tb_renaming_table_mp.sv
// tb_renaming_table_mp: directed checks of the rename table with default parameters.
// Checkpoint vectors run only when RT_CKPT_EN is defined.
module tb_renaming_table_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] i_rd_addr;
  logic [3:0]  o_rd_busy;
  logic [23:0] o_rd_rrftag;
  logic [1:0]  i_dp_vld;
  logic [1:0]  i_dp_rd_wr_en;
  logic [11:0] i_dp_ptr;
  logic [9:0]  i_dp_rd_wr_addr;
  logic [1:0]  i_com_vld;
  logic [9:0]  i_com_rd_wr_addr;
  logic [11:0] i_com_ptr;
  logic        i_flush;
  logic        i_ckpt_save;
  logic [1:0]  o_ckpt_id;
  logic        o_ckpt_full;
  logic        i_ckpt_restore;
  logic [1:0]  i_ckpt_restore_id;
  logic        i_ckpt_release;

`ifdef RT_CKPT_EN
  localparam logic FULL_AT_RESET = 1'b0;
`else
  localparam logic FULL_AT_RESET = 1'b1;
`endif

  int checks = 0;
  int errors = 0;

  renaming_table_mp dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_rd_addr         (i_rd_addr),
    .o_rd_busy         (o_rd_busy),
    .o_rd_rrftag       (o_rd_rrftag),
    .i_dp_vld          (i_dp_vld),
    .i_dp_rd_wr_en     (i_dp_rd_wr_en),
    .i_dp_ptr          (i_dp_ptr),
    .i_dp_rd_wr_addr   (i_dp_rd_wr_addr),
    .i_com_vld         (i_com_vld),
    .i_com_rd_wr_addr  (i_com_rd_wr_addr),
    .i_com_ptr         (i_com_ptr),
    .i_flush           (i_flush),
    .i_ckpt_save       (i_ckpt_save),
    .o_ckpt_id         (o_ckpt_id),
    .o_ckpt_full       (o_ckpt_full),
    .i_ckpt_restore    (i_ckpt_restore),
    .i_ckpt_restore_id (i_ckpt_restore_id),
    .i_ckpt_release    (i_ckpt_release)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    i_dp_vld          = '0;
    i_dp_rd_wr_en     = '0;
    i_dp_ptr          = '0;
    i_dp_rd_wr_addr   = '0;
    i_com_vld         = '0;
    i_com_rd_wr_addr  = '0;
    i_com_ptr         = '0;
    i_flush           = 1'b0;
    i_ckpt_save       = 1'b0;
    i_ckpt_restore    = 1'b0;
    i_ckpt_restore_id = '0;
    i_ckpt_release    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic dp(input int p, input int a, input int ptr, input bit en = 1'b1);
    i_dp_vld[p]                = 1'b1;
    i_dp_rd_wr_en[p]           = en;
    i_dp_ptr[p*6 +: 6]         = 6'(ptr);
    i_dp_rd_wr_addr[p*5 +: 5]  = 5'(a);
  endtask

  task automatic cm(input int p, input int a, input int ptr);
    i_com_vld[p]               = 1'b1;
    i_com_ptr[p*6 +: 6]        = 6'(ptr);
    i_com_rd_wr_addr[p*5 +: 5] = 5'(a);
  endtask

  task automatic look(input int p, input int a, input int eb, input int et, input string tag);
    i_rd_addr[p*5 +: 5] = 5'(a);
    #1;
    check({tag, "_busy"}, 32'(o_rd_busy[p]), eb);
    check({tag, "_tag"}, 32'(o_rd_rrftag[p*6 +: 6]), et);
  endtask

  initial begin
    clr();
    i_rd_addr = {5'd3, 5'd9, 5'd7, 5'd5};
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(o_rd_busy), 0);
    check("rst_tag", 32'(o_rd_rrftag), 0);
    check("rst_ckpt_id", 32'(o_ckpt_id), 0);
    check("rst_ckpt_full", 32'(o_ckpt_full), 32'(FULL_AT_RESET));
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // basic dispatch then matching commit
    dp(0, 5, 12);
    step();
    look(0, 5, 1, 12, "t1_disp");
    cm(0, 5, 12);
    step();
    look(1, 5, 0, 12, "t1_com");

    // same-cycle same-register dispatch: younger port wins; stale commit keeps busy
    dp(0, 7, 3);
    dp(1, 7, 4);
    step();
    look(2, 7, 1, 4, "t2_disp");
    cm(1, 7, 3);
    step();
    look(2, 7, 1, 4, "t2_stale_com");
    cm(0, 7, 4);
    step();
    look(3, 7, 0, 4, "t2_com");

    // register 0 ignored; dispatch without rd write leaves entry alone
    dp(1, 0, 9);
    dp(0, 11, 5, 1'b0);
    step();
    look(0, 0, 0, 0, "t3_x0");
    look(1, 11, 0, 0, "t3_no_wr");

    // commit and dispatch to same register: dispatch wins
    dp(0, 9, 2);
    step();
    cm(0, 9, 2);
    dp(1, 9, 20);
    step();
    look(2, 9, 1, 20, "t4_dp_over_com");

    // two commit ports plus a dispatch in one cycle
    dp(0, 12, 40);
    dp(1, 13, 41);
    step();
    cm(0, 12, 40);
    cm(1, 13, 41);
    dp(0, 14, 42);
    step();
    look(0, 12, 0, 40, "t5_com0");
    look(1, 13, 0, 41, "t5_com1");
    look(2, 14, 1, 42, "t5_disp");

    // flush clears busy, keeps tags, drops same-cycle dispatch
    dp(0, 15, 50);
    i_flush = 1'b1;
    step();
    look(0, 9, 0, 20, "fl_r9");
    look(1, 14, 0, 42, "fl_r14");
    look(2, 15, 0, 0, "fl_r15");

    // asynchronous reset mid-operation
    dp(0, 16, 17);
    dp(1, 17, 18);
    step();
    i_rd_addr = {5'd17, 5'd16, 5'd17, 5'd16};
    #1;
    check("pre_rst_busy", 32'(o_rd_busy), 32'hF);
    check("pre_rst_tag", 32'(o_rd_rrftag), 32'({6'd18, 6'd17, 6'd18, 6'd17}));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(o_rd_busy), 0);
    check("async_rst_tag", 32'(o_rd_rrftag), 0);
    check("async_rst_full", 32'(o_ckpt_full), 32'(FULL_AT_RESET));
    dp(0, 18, 5);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    look(0, 18, 1, 5, "post_rst_disp");
    look(1, 16, 0, 0, "post_rst_r16");

`ifdef RT_CKPT_EN
    // save with dispatch, later dispatch, restore
    dp(0, 3, 1);
    i_ckpt_save = 1'b1;
    #1;
    check("ck_id_first", 32'(o_ckpt_id), 0);
    step();
    check("ck_id_after_save", 32'(o_ckpt_id), 1);
    dp(0, 3, 2);
    step();
    look(0, 3, 1, 2, "ck_young");
    i_ckpt_restore = 1'b1;
    i_ckpt_restore_id = 2'd0;
    step();
    look(0, 3, 1, 1, "ck_restored");
    check("ck_id_restored", 32'(o_ckpt_id), 0);
    check("ck_full_restored", 32'(o_ckpt_full), 0);

    // four saves fill the ring; fifth is dropped
    repeat (4) begin
      i_ckpt_save = 1'b1;
      step();
    end
    check("ck_full4", 32'(o_ckpt_full), 1);
    check("ck_id4", 32'(o_ckpt_id), 0);
    i_ckpt_save = 1'b1;
    step();
    check("ck_full5", 32'(o_ckpt_full), 1);
    check("ck_id5", 32'(o_ckpt_id), 0);
    i_flush = 1'b1;
    step();
    check("ck_flush_full", 32'(o_ckpt_full), 0);

    // release + restore to non-head slot in the same cycle
    i_ckpt_save = 1'b1;
    step();
    i_ckpt_save = 1'b1;
    step();
    i_ckpt_release = 1'b1;
    i_ckpt_restore = 1'b1;
    i_ckpt_restore_id = 2'd1;
    step();
    check("ck_relres_id", 32'(o_ckpt_id), 1);
    check("ck_relres_full", 32'(o_ckpt_full), 0);
    i_ckpt_release = 1'b1;
    step();
    repeat (3) begin
      i_ckpt_save = 1'b1;
      step();
    end
    check("ck_cnt3_full", 32'(o_ckpt_full), 0);
    i_ckpt_save = 1'b1;
    step();
    check("ck_cnt4_full", 32'(o_ckpt_full), 1);
    check("ck_cnt4_id", 32'(o_ckpt_id), 1);
`else
    // checkpoint inputs have no effect
    i_ckpt_save = 1'b1;
    dp(0, 3, 1);
    step();
    i_ckpt_restore = 1'b1;
    i_ckpt_restore_id = 2'd0;
    dp(0, 3, 2);
    step();
    look(0, 3, 1, 2, "nock_restore_ignored");
    check("nock_id", 32'(o_ckpt_id), 0);
    check("nock_full", 32'(o_ckpt_full), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
